pipe_stage_skid: RTL

Parametrised elastic pipeline stage that replaces fixed, always-advancing stage registers (such as ID->EX) with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble semantics.
- Payload is split into CTRL (write-enables, selects, halt) and DATA (immediates, register ids).
- CTRL is forced to zero whenever the stage holds no valid entry, so a bubble never writes memory or registers.
- One instance sits between each pair of CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_entry_reg.sv | 34 +++
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: FSM state encoding,
// per-stage payload widths and ctrl-vector bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned IF_ID_CTRL_W  = 4;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 12;
  localparam int unsigned ID_EX_DATA_W  = 56;
  localparam int unsigned EX_MEM_CTRL_W = 8;
  localparam int unsigned EX_MEM_DATA_W = 72;
  localparam int unsigned MEM_WB_CTRL_W = 4;
  localparam int unsigned MEM_WB_DATA_W = 40;

  localparam int unsigned STALL_CNT_W   = 16;

  // Side-effecting bits inside every ctrl vector; all must read 0 on a bubble.
  localparam int unsigned WB_WE_BIT  = 0;
  localparam int unsigned MEM_WE_BIT = 1;
  localparam int unsigned HLT_BIT    = 2;

  typedef struct packed {
    logic [ID_EX_CTRL_W-1:0] ctrl;
    logic [ID_EX_DATA_W-1:0] data;
  } id_ex_payload_t;

  function automatic logic [1:0] occ_of(input state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage entry (ctrl + data) with load enable and a ctrl-only clear so a
// dropped or drained entry can never leak write-enables downstream.
module pipe_entry_reg #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned DATA_W = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [DATA_W-1:0] next_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clear beats load for ctrl; data only changes on a real load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl <= '0;
      data <= '0;
    end else begin
      if (clr) begin
        ctrl <= '0;
      end else if (load) begin
        ctrl <= next_ctrl;
      end
      if (load) begin
        data <= next_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, flush,
// bubble ctrl-zeroing and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter int unsigned CNT_W  = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state;
  state_e            state_nxt;
  logic              up_fire;
  logic              dn_fire;
  logic              main_load;
  logic              main_from_skid;
  logic              main_clr;
  logic              skid_load;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_next_ctrl;
  logic [DATA_W-1:0] main_next_data;

  assign dn_valid  = (state != ST_EMPTY);
  assign occupancy = occ_of(state);
  assign up_fire   = up_valid & up_ready;
  assign dn_fire   = dn_valid & dn_ready;

  // Next state and entry-register enables; flush overrides every transfer.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (up_fire) begin
          state_nxt = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (up_fire && dn_fire) begin
          main_load = 1'b1;
        end else if (up_fire) begin
          state_nxt = ST_FULL;
          skid_load = 1'b1;
        end else if (dn_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (dn_fire) begin
          state_nxt      = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = ST_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  assign main_clr       = (state_nxt == ST_EMPTY);
  assign main_next_ctrl = main_from_skid ? skid_ctrl : up_ctrl;
  assign main_next_data = main_from_skid ? skid_data : up_data;

  // up_ready is registered from next state, so dn_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      up_ready  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      up_ready <= (state_nxt != ST_FULL);
      if (dn_valid && !dn_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .clr       (main_clr),
    .next_ctrl (main_next_ctrl),
    .next_data (main_next_data),
    .ctrl      (dn_ctrl),
    .data      (dn_data)
  );

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clr       (flush),
    .next_ctrl (up_ctrl),
    .next_data (up_data),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );

endmodule
